prbs7_chk: RTL and testbench

PRBS7_CHK -- requirements
Module: prbs7_chk

---
 rtl/prbs7_chk.sv | 110 +++++++++++
 tb/tb_prbs7_chk.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_chk.sv
// rtl/prbs7_chk.sv - PRBS7 (x^7+x^6+1) receive checker with lock search,
// free-running error detection, windowed loss-of-lock and saturating error count.
module prbs7_chk #(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_THR = 4
) (
   input  logic        CK,
   input  logic        CD,
   input  logic        DI,
   input  logic        DV,
   input  logic        CLR,
   output logic        LOCK,
   output logic        ERR,
   output logic [15:0] ERRCNT
);

   typedef enum logic {SEARCH, LOCKED} state_t;

   localparam logic [7:0] LP_LOCK = 8'(LOCK_CNT);
   localparam logic [6:0] LP_LOSS = 7'(LOSS_THR);

   state_t      r_state;
   logic [6:0]  r_s;
   logic [2:0]  r_fill;
   logic [7:0]  r_mc;
   logic [5:0]  r_win;
   logic [6:0]  r_we;
   logic        r_lock;
   logic        r_err;
   logic [15:0] r_cnt;

   logic        w_p;
   logic        w_mis;
   logic        w_zero;
   logic [6:0]  w_we_nxt;
   logic        w_loss;
   logic [7:0]  w_mc_nxt;

   assign w_p      = r_s[6] ^ r_s[5];
   assign w_mis    = DI ^ w_p;
   assign w_zero   = (r_s == 7'd0);
   assign w_we_nxt = r_we + {6'd0, w_mis};
   assign w_loss   = w_mis && (w_we_nxt >= LP_LOSS);
   assign w_mc_nxt = r_mc + 8'd1;

   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         r_state <= SEARCH;
         r_s     <= 7'd0;
         r_fill  <= 3'd0;
         r_mc    <= 8'd0;
         r_win   <= 6'd0;
         r_we    <= 7'd0;
         r_lock  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= 16'd0;
      end else begin
         r_err <= 1'b0;
         if (DV) begin
            case (r_state)
               SEARCH: begin
                  r_s <= {r_s[5:0], DI};
                  if (r_fill != 3'd7) begin
                     r_fill <= r_fill + 3'd1;
                  end else if (w_zero || w_mis) begin
                     // an all-zero register predicts zeros forever, so it never earns matches
                     r_mc <= 8'd0;
                  end else if (w_mc_nxt == LP_LOCK) begin
                     r_state <= LOCKED;
                     r_lock  <= 1'b1;
                     r_mc    <= 8'd0;
                     r_win   <= 6'd0;
                     r_we    <= 7'd0;
                  end else begin
                     r_mc <= w_mc_nxt;
                  end
               end
               LOCKED: begin
                  // free-run on the prediction so a line error cannot corrupt later predictions
                  r_s   <= {r_s[5:0], w_p};
                  r_err <= w_mis;
                  if (w_mis && (r_cnt != 16'hFFFF)) begin
                     r_cnt <= r_cnt + 16'd1;
                  end
                  if (w_loss) begin
                     r_state <= SEARCH;
                     r_lock  <= 1'b0;
                     r_fill  <= 3'd0;
                     r_mc    <= 8'd0;
                     r_we    <= 7'd0;
                     r_win   <= 6'd0;
                  end else begin
                     r_win <= r_win + 6'd1;
                     r_we  <= (r_win == 6'd63) ? 7'd0 : w_we_nxt;
                  end
               end
               default: r_state <= SEARCH;
            endcase
         end
         if (CLR) begin
            r_cnt <= 16'd0;
         end
      end
   end

   assign LOCK   = r_lock;
   assign ERR    = r_err;
   assign ERRCNT = r_cnt;

endmodule

// File: tb/tb_prbs7_chk.sv
// tb/tb_prbs7_chk.sv - scoreboard bench for prbs7_chk with a behavioural model,
// directed lock/loss/clear/reset scenarios and a saturation run on a second instance.
module tb_prbs7_chk;

   localparam int LOCK_CNT = 16;
   localparam int LOSS_THR = 4;

   logic        CK = 1'b0;
   logic        CD = 1'b1, DI = 1'b0, DV = 1'b0, CLR = 1'b0;
   logic        LOCK, ERR;
   logic [15:0] ERRCNT;
   logic        CD2 = 1'b1, DI2 = 1'b0, DV2 = 1'b0, CLR2 = 1'b0;
   logic        LOCK2, ERR2;
   logic [15:0] ERRCNT2;

   int n_chk = 0;
   int n_err = 0;

   always #5 CK = ~CK;

   prbs7_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR)) u_dut (
      .CK(CK), .CD(CD), .DI(DI), .DV(DV), .CLR(CLR),
      .LOCK(LOCK), .ERR(ERR), .ERRCNT(ERRCNT));

   prbs7_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(64)) u_sat (
      .CK(CK), .CD(CD2), .DI(DI2), .DV(DV2), .CLR(CLR2),
      .LOCK(LOCK2), .ERR(ERR2), .ERRCNT(ERRCNT2));

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // pattern generator: next bit = s[6]^s[5], shifted in as the newest bit
   function automatic logic [6:0] lfsr_adv(input logic [6:0] st);
      return {st[5:0], st[6] ^ st[5]};
   endfunction

   // behavioural reference: register kept as a bit queue, oldest first
   typedef struct {bit lock; bit err; int cnt;} exp_t;
   exp_t exp_q[$];
   bit   m_s[$];
   bit   m_lock;
   int   m_fill, m_mc, m_we, m_nlk, m_cnt;

   task automatic mdl_reset();
      m_s.delete();
      for (int i = 0; i < 7; i++) m_s.push_back(1'b0);
      m_lock = 0; m_fill = 0; m_mc = 0; m_we = 0; m_nlk = 0; m_cnt = 0;
   endtask

   task automatic mdl_step(input bit di, input bit dv, input bit clr);
      bit   p, e;
      int   ones;
      exp_t x;
      e = 0;
      if (dv) begin
         p = m_s[0] ^ m_s[1];
         ones = 0;
         foreach (m_s[i]) ones += int'(m_s[i]);
         if (!m_lock) begin
            if (m_fill < 7) m_fill++;
            else if (ones != 0 && di == p) begin
               m_mc++;
               if (m_mc == LOCK_CNT) begin
                  m_lock = 1; m_nlk = 0; m_we = 0; m_mc = 0;
               end
            end else m_mc = 0;
            m_s.push_back(di);
         end else begin
            m_s.push_back(p);
            e = (di != p);
            if (e) begin
               if (m_cnt < 65535) m_cnt++;
               m_we++;
            end
            if (e && m_we >= LOSS_THR) begin
               m_lock = 0; m_fill = 0; m_mc = 0; m_we = 0;
            end else begin
               m_nlk++;
               if (m_nlk % 64 == 0) m_we = 0;
            end
         end
         void'(m_s.pop_front());
      end
      if (clr) m_cnt = 0;
      x.lock = m_lock; x.err = e; x.cnt = m_cnt;
      exp_q.push_back(x);
   endtask

   exp_t mon_x;
   always @(negedge CK) begin
      if (exp_q.size() > 0) begin
         mon_x = exp_q.pop_front();
         n_chk++;
         if (LOCK !== mon_x.lock || ERR !== mon_x.err || ERRCNT !== 16'(mon_x.cnt)) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got lock=%0b err=%0b cnt=%0d expected lock=%0b err=%0b cnt=%0d",
                     $time, LOCK, ERR, ERRCNT, mon_x.lock, mon_x.err, mon_x.cnt);
         end
      end
   end

   task automatic cyc(input bit di, input bit dv, input bit clr);
      DI = di; DV = dv; CLR = clr;
      @(posedge CK);
      #1;
      mdl_step(di, dv, clr);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CK);
      #1;
      CD = 1'b1; DV = 1'b0; CLR = 1'b0;
      #1;
      chk({tag, "_lock"}, int'(LOCK), 0);
      chk({tag, "_err"}, int'(ERR), 0);
      chk({tag, "_cnt"}, int'(ERRCNT), 0);
      mdl_reset();
      @(posedge CK);
      #1;
      CD = 1'b0;
   endtask

   logic [6:0] g;

   task automatic clean_bits(input int n);
      for (int i = 0; i < n; i++) begin
         g = lfsr_adv(g);
         cyc(g[0], 1'b1, 1'b0);
      end
   endtask

   task automatic lock_up(input string tag);
      for (int i = 1; i <= 23; i++) begin
         g = lfsr_adv(g);
         cyc(g[0], 1'b1, 1'b0);
         if (i == 22) chk({tag, "_nolock22"}, int'(LOCK), 0);
         if (i == 23) chk({tag, "_lock23"}, int'(LOCK), 1);
      end
   endtask

   task automatic main_seq();
      int n_pulse, nvalid, burst;
      bit e, dv;
      // lock timing from seed 7F
      do_reset("rst0");
      g = 7'h7F;
      lock_up("seed");
      clean_bits(100);
      chk("clean_cnt", int'(ERRCNT), 0);
      // single inverted bit
      g = lfsr_adv(g);
      cyc(~g[0], 1'b1, 1'b0);
      chk("single_err", int'(ERR), 1);
      chk("single_cnt", int'(ERRCNT), 1);
      chk("single_lock", int'(LOCK), 1);
      n_pulse = 0;
      for (int i = 0; i < 100; i++) begin
         g = lfsr_adv(g);
         cyc(g[0], 1'b1, 1'b0);
         n_pulse += int'(ERR);
      end
      chk("single_after", n_pulse, 0);
      // 3+3 errors across two windows, then 4 in one window
      do_reset("rst1");
      g = 7'h7F;
      lock_up("win");
      for (int j = 0; j <= 143; j++) begin
         e = (j == 10 || j == 20 || j == 30 || j == 70 || j == 80 || j == 90 || j >= 140);
         g = lfsr_adv(g);
         cyc(g[0] ^ e, 1'b1, 1'b0);
         if (j == 139) begin
            chk("win33_lock", int'(LOCK), 1);
            chk("win33_cnt", int'(ERRCNT), 6);
         end
         if (j == 142) chk("win4_third_lock", int'(LOCK), 1);
      end
      chk("win4_lock", int'(LOCK), 0);
      chk("win4_cnt", int'(ERRCNT), 10);
      chk("win4_err", int'(ERR), 1);
      lock_up("relock");
      // clear coinciding with an error
      g = lfsr_adv(g);
      cyc(~g[0], 1'b1, 1'b1);
      chk("clr_err", int'(ERR), 1);
      chk("clr_cnt", int'(ERRCNT), 0);
      // DV toggling while locked
      for (int i = 0; i < 200; i++) begin
         if (i % 2 == 0) begin
            g = lfsr_adv(g);
            cyc(g[0], 1'b1, 1'b0);
         end else cyc(1'($urandom), 1'b0, 1'b0);
      end
      chk("toggle_lock", int'(LOCK), 1);
      chk("toggle_cnt", int'(ERRCNT), 0);
      do_reset("rst_mid");
      nvalid = 0;
      for (int i = 0; i < 120 && LOCK !== 1'b1; i++) begin
         if (i % 2 == 0) begin
            g = lfsr_adv(g);
            cyc(g[0], 1'b1, 1'b0);
            nvalid++;
         end else cyc(1'($urandom), 1'b0, 1'b0);
      end
      chk("mid_relock_bits", nvalid, 23);
      // constant zero never locks
      do_reset("rst_zero");
      for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 1'b0);
      chk("zero_lock", int'(LOCK), 0);
      chk("zero_cnt", int'(ERRCNT), 0);
      // randomized traffic
      do_reset("rst_rand");
      g = 7'($urandom_range(1, 127));
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
         dv = ($urandom_range(0, 4) != 0);
         if (dv) begin
            g = lfsr_adv(g);
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(2, 5);
            e = (burst > 0) || ($urandom_range(0, 59) == 0);
            if (burst > 0) burst--;
            cyc(g[0] ^ e, 1'b1, $urandom_range(0, 149) == 0);
         end else cyc(1'($urandom), 1'b0, $urandom_range(0, 149) == 0);
      end
   endtask

   logic [6:0] g2;

   task automatic sat_step(input bit e);
      g2 = lfsr_adv(g2);
      DI2 = g2[0] ^ e; DV2 = 1'b1;
      @(posedge CK);
      #1;
   endtask

   task automatic sat_seq();
      int errs, k;
      repeat (2) @(posedge CK);
      #1;
      CD2 = 1'b0;
      g2 = 7'h7F;
      for (int i = 0; i < 23; i++) sat_step(1'b0);
      chk("sat_locked", int'(LOCK2), 1);
      errs = 0; k = 0;
      while (errs < 65535) begin
         sat_step(k != 63);
         if (k != 63) errs++;
         k = (k + 1) % 64;
      end
      chk("sat_full", int'(ERRCNT2), 65535);
      chk("sat_lock", int'(LOCK2), 1);
      if (k == 63) sat_step(1'b0);
      sat_step(1'b1);
      chk("sat_hold", int'(ERRCNT2), 65535);
      chk("sat_err", int'(ERR2), 1);
      DV2 = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mdl_reset();
      fork
         main_seq();
         sat_seq();
      join
      repeat (3) @(negedge CK);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
